// File: rtl/tv_fx_pkg.sv
// Shared constants for the tv_fx scanline sequencer: effect modes, FSM states and
// the configuration that is active after reset.
package tv_fx_pkg;

    localparam logic [1:0] MODE_PASS      = 2'b00;
    localparam logic [1:0] MODE_DIM       = 2'b01;
    localparam logic [1:0] MODE_DELAY     = 2'b10;
    localparam logic [1:0] MODE_DELAY_DIM = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StVblank = 2'b01,
        StActive = 2'b10
    } state_e;

    localparam int unsigned DEF_PERIOD    = 1;
    localparam int unsigned DEF_ON        = 0;
    localparam logic [1:0]  DEF_MODE      = MODE_PASS;
    localparam logic        DEF_ANIM_EN   = 1'b0;
    localparam int unsigned DEF_ANIM_RATE = 0;

endpackage

// File: rtl/sync_edge_det.sv
// Two-stage input register with a registered rising-edge pulse; the pulse lands
// one cycle after the second stage so downstream state moves two edges after sampling.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic qq;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            qq   <= 1'b0;
            rise <= 1'b0;
        end else begin
            q    <= d;
            qq   <= q;
            rise <= q & ~qq;
        end
    end

endmodule

// File: rtl/tv_fx_sequencer.sv
// Line/frame scheduler: turns hs/vs into a per-line effect enable and mode, with
// shadowed configuration that only switches at frame start.
module tv_fx_sequencer
    import tv_fx_pkg::*;
#(
    parameter int unsigned LINE_W = 11,
    parameter int unsigned ANIM_W = 8
) (
    input  logic              pixclk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              cfg_we,
    input  logic [LINE_W-1:0] cfg_period,
    input  logic [LINE_W-1:0] cfg_on,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_anim_en,
    input  logic [ANIM_W-1:0] cfg_anim_rate,
    output logic              cfg_ack,
    output logic              fx_en,
    output logic [1:0]        fx_mode,
    output logic [LINE_W-1:0] line_cnt,
    output logic              frame_tick
);

    typedef struct packed {
        logic [LINE_W-1:0] period;
        logic [LINE_W-1:0] on;
        logic [1:0]        mode;
        logic              anim_en;
        logic [ANIM_W-1:0] anim_rate;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        period:    LINE_W'(DEF_PERIOD),
        on:        LINE_W'(DEF_ON),
        mode:      DEF_MODE,
        anim_en:   DEF_ANIM_EN,
        anim_rate: ANIM_W'(DEF_ANIM_RATE)
    };

    logic unused_hs_q;
    logic hs_rise, vs_q, vs_rise;

    state_e            state_q, state_d;
    cfg_t              cfg_in, pend_q, pend_d, act_q, act_d;
    logic              pend_v_q, pend_v_d;
    logic [LINE_W-1:0] phase_q, phase_d, phase_inc, period_eff;
    logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
    logic [1:0]        anim_ofs_q, anim_ofs_d;
    logic              fx_en_q, fx_en_d, cfg_ack_q, cfg_ack_d, frame_tick_q, frame_tick_d;
    logic [1:0]        fx_mode_q, fx_mode_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;

    sync_edge_det u_hs_det (
        .clk  (pixclk),
        .rst  (rst),
        .d    (hs),
        .q    (unused_hs_q),
        .rise (hs_rise)
    );

    sync_edge_det u_vs_det (
        .clk  (pixclk),
        .rst  (rst),
        .d    (vs),
        .q    (vs_q),
        .rise (vs_rise)
    );

    assign cfg_in     = {cfg_period, cfg_on, cfg_mode, cfg_anim_en, cfg_anim_rate};
    assign period_eff = (act_q.period == '0) ? LINE_W'(1) : act_q.period;
    assign phase_inc  = phase_q + LINE_W'(1);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        act_d        = act_q;
        phase_d      = phase_q;
        anim_cnt_d   = anim_cnt_q;
        anim_ofs_d   = anim_ofs_q;
        fx_en_d      = fx_en_q;
        fx_mode_d    = fx_mode_q;
        line_cnt_d   = line_cnt_q;
        cfg_ack_d    = 1'b0;
        frame_tick_d = 1'b0;

        // A write landing on the frame-start cycle bypasses the shadow and wins.
        if (vs_rise) begin
            if (cfg_we) begin
                act_d     = cfg_in;
                cfg_ack_d = 1'b1;
                pend_v_d  = 1'b0;
            end else if (pend_v_q) begin
                act_d     = pend_q;
                cfg_ack_d = 1'b1;
                pend_v_d  = 1'b0;
            end
        end else if (cfg_we) begin
            pend_d   = cfg_in;
            pend_v_d = 1'b1;
        end

        if (vs_rise) begin
            state_d      = StVblank;
            frame_tick_d = 1'b1;
            fx_en_d      = 1'b0;
            line_cnt_d   = '0;
            phase_d      = '0;
            // Mode for this frame uses the offset before this frame's divider step.
            fx_mode_d    = act_d.mode + (act_d.anim_en ? anim_ofs_q : 2'b00);
            if (!act_d.anim_en) begin
                anim_cnt_d = '0;
                anim_ofs_d = 2'b00;
            end else if (anim_cnt_q == act_d.anim_rate) begin
                anim_cnt_d = '0;
                anim_ofs_d = anim_ofs_q + 2'b01;
            end else begin
                anim_cnt_d = anim_cnt_q + ANIM_W'(1);
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StVblank: begin
                    fx_en_d    = 1'b0;
                    line_cnt_d = '0;
                    phase_d    = '0;
                    if (!vs_q) state_d = StActive;
                end
                StActive: begin
                    if (hs_rise) begin
                        line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + LINE_W'(1);
                        fx_en_d    = (phase_q < act_q.on);
                        phase_d    = (phase_inc == period_eff) ? '0 : phase_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            act_q        <= CFG_RST;
            phase_q      <= '0;
            anim_cnt_q   <= '0;
            anim_ofs_q   <= 2'b00;
            fx_en_q      <= 1'b0;
            fx_mode_q    <= 2'b00;
            line_cnt_q   <= '0;
            cfg_ack_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            act_q        <= act_d;
            phase_q      <= phase_d;
            anim_cnt_q   <= anim_cnt_d;
            anim_ofs_q   <= anim_ofs_d;
            fx_en_q      <= fx_en_d;
            fx_mode_q    <= fx_mode_d;
            line_cnt_q   <= line_cnt_d;
            cfg_ack_q    <= cfg_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign cfg_ack    = cfg_ack_q;
    assign fx_en      = fx_en_q;
    assign fx_mode    = fx_mode_q;
    assign line_cnt   = line_cnt_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tv_fx_sequencer.sv
// Self-checking bench for tv_fx_sequencer: table of line patterns, a line scoreboard
// popped whenever line_cnt advances, and hand sequences for latency, shadowing and reset.
module tb_tv_fx_sequencer;
    import tv_fx_pkg::*;

    localparam int unsigned LW = 11;
    localparam int unsigned AW = 8;

    logic          pixclk = 1'b0;
    logic          rst = 1'b1;
    logic          hs = 1'b0;
    logic          vs = 1'b0;
    logic          cfg_we = 1'b0;
    logic [LW-1:0] cfg_period = '0;
    logic [LW-1:0] cfg_on = '0;
    logic [1:0]    cfg_mode = 2'b00;
    logic          cfg_anim_en = 1'b0;
    logic [AW-1:0] cfg_anim_rate = '0;
    logic          cfg_ack, fx_en, frame_tick;
    logic [1:0]    fx_mode;
    logic [LW-1:0] line_cnt;

    tv_fx_sequencer #(.LINE_W(LW), .ANIM_W(AW)) dut (
        .pixclk        (pixclk),
        .rst           (rst),
        .hs            (hs),
        .vs            (vs),
        .cfg_we        (cfg_we),
        .cfg_period    (cfg_period),
        .cfg_on        (cfg_on),
        .cfg_mode      (cfg_mode),
        .cfg_anim_en   (cfg_anim_en),
        .cfg_anim_rate (cfg_anim_rate),
        .cfg_ack       (cfg_ack),
        .fx_en         (fx_en),
        .fx_mode       (fx_mode),
        .line_cnt      (line_cnt),
        .frame_tick    (frame_tick)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        int         line;
        logic       en;
        logic [1:0] mode;
    } exp_t;

    typedef struct {
        int         period;
        int         on;
        logic [1:0] mode;
        logic [5:0] en_mask;
    } vec_t;

    exp_t          sb[$];
    exp_t          mon_e;
    vec_t          tbl[6];
    logic [1:0]    anim_exp[7];
    int            checks = 0;
    int            errors = 0;
    int            line_no = 0;
    logic [LW-1:0] prev_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pixclk);
    endtask

    task automatic write_cfg(input int p, input int on, input logic [1:0] m, input logic ae,
                             input int rate);
        cfg_period    = p[LW-1:0];
        cfg_on        = on[LW-1:0];
        cfg_mode      = m;
        cfg_anim_en   = ae;
        cfg_anim_rate = rate[AW-1:0];
        cfg_we        = 1'b1;
        cyc(1);
        cfg_we        = 1'b0;
    endtask

    task automatic frame(input string tag, input logic exp_ack);
        vs = 1'b1;
        cyc(1);
        vs = 1'b0;
        cyc(2);
        check({tag, "_tick"}, frame_tick, 1);
        check({tag, "_ack"}, cfg_ack, exp_ack);
        cyc(1);
        check({tag, "_tick_pulse"}, frame_tick, 0);
        line_no = 0;
    endtask

    task automatic frame_bypass(input string tag, input int p, input int on, input logic [1:0] m);
        vs = 1'b1;
        cyc(1);
        vs = 1'b0;
        cyc(1);
        write_cfg(p, on, m, 1'b0, 0);
        check({tag, "_tick"}, frame_tick, 1);
        check({tag, "_ack"}, cfg_ack, 1);
        check({tag, "_mode"}, fx_mode, m);
        cyc(1);
        line_no = 0;
    endtask

    task automatic line(input logic en, input logic [1:0] mode);
        line_no++;
        sb.push_back('{line_no, en, mode});
        hs = 1'b1;
        cyc(1);
        hs = 1'b0;
        cyc(3);
    endtask

    // A new line is visible whenever line_cnt steps to a nonzero value.
    always @(negedge pixclk) begin
        if (!rst && line_cnt != prev_cnt && line_cnt != '0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_line", line_cnt, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_line_cnt", line_cnt, mon_e.line);
                check("sb_fx_en", fx_en, mon_e.en);
                check("sb_fx_mode", fx_mode, mon_e.mode);
            end
        end
        prev_cnt <= line_cnt;
    end

    initial begin
        tbl[0] = '{2, 1, MODE_DIM, 6'b010101};
        tbl[1] = '{0, 0, MODE_PASS, 6'b000000};
        tbl[2] = '{3, 5, MODE_DELAY_DIM, 6'b111111};
        tbl[3] = '{4, 3, MODE_DELAY, 6'b110111};
        tbl[4] = '{3, 1, MODE_PASS, 6'b001001};
        tbl[5] = '{5, 2, MODE_DIM, 6'b100011};
        anim_exp = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01};

        // Reset state, then hs alone must not leave IDLE.
        cyc(3);
        check("rst_fx_en", fx_en, 0);
        check("rst_fx_mode", fx_mode, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        rst = 1'b0;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            hs = 1'b1;
            cyc(1);
            hs = 1'b0;
            cyc(3);
            check("idle_fx_en", fx_en, 0);
            check("idle_line_cnt", line_cnt, 0);
            check("idle_state", int'(dut.state_q), int'(StIdle));
        end

        // Line patterns from the table, one frame each.
        for (int i = 0; i < 6; i++) begin
            write_cfg(tbl[i].period, tbl[i].on, tbl[i].mode, 1'b0, 0);
            frame("tbl_frame", 1'b1);
            check("tbl_mode", fx_mode, tbl[i].mode);
            for (int l = 0; l < 6; l++) line(tbl[i].en_mask[l], tbl[i].mode);
        end

        // Two-edge latency from hs sample, then a mid-frame write held until next vs.
        write_cfg(2, 1, MODE_DIM, 1'b0, 0);
        frame("lat_frame", 1'b1);
        line_no++;
        sb.push_back('{line_no, 1'b1, MODE_DIM});
        hs = 1'b1;
        cyc(1);
        hs = 1'b0;
        check("lat_edge_k", fx_en, 0);
        cyc(1);
        check("lat_edge_k1", fx_en, 0);
        check("lat_edge_k1_cnt", line_cnt, 0);
        cyc(1);
        check("lat_edge_k2", fx_en, 1);
        cyc(1);
        line(1'b0, MODE_DIM);
        write_cfg(4, 2, MODE_DELAY_DIM, 1'b0, 0);
        check("mid_no_ack", cfg_ack, 0);
        line(1'b1, MODE_DIM);
        write_cfg(4, 3, MODE_DELAY, 1'b0, 0);
        line(1'b0, MODE_DIM);
        line(1'b1, MODE_DIM);
        frame("mid_apply", 1'b1);
        check("mid_last_wins_mode", fx_mode, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        line(1'b0, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        frame("mid_no_pending", 1'b0);

        // Write coincident with frame start goes straight to the active set.
        frame_bypass("byp1", 3, 5, MODE_DIM);
        for (int l = 0; l < 3; l++) line(1'b1, MODE_DIM);
        write_cfg(0, 0, MODE_PASS, 1'b0, 0);
        frame_bypass("byp2", 2, 1, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        line(1'b0, MODE_DELAY);
        line(1'b1, MODE_DELAY);
        frame("byp_cleared", 1'b0);
        line(1'b1, MODE_DELAY);

        // Mode animation, then disabling it.
        write_cfg(1, 1, MODE_DELAY, 1'b1, 1);
        for (int f = 0; f < 7; f++) begin
            frame("anim_frame", f == 0);
            check("anim_mode", fx_mode, anim_exp[f]);
            line(1'b1, anim_exp[f]);
        end
        write_cfg(1, 1, MODE_DIM, 1'b0, 0);
        frame("anim_off", 1'b1);
        check("anim_off_mode", fx_mode, MODE_DIM);
        line(1'b1, MODE_DIM);
        frame("anim_off2", 1'b0);
        check("anim_off_mode2", fx_mode, MODE_DIM);

        // Reset mid-frame drops the pending write; hs and vs together favour vs.
        write_cfg(1, 1, MODE_DIM, 1'b0, 0);
        frame("pre_rst", 1'b1);
        line(1'b1, MODE_DIM);
        line(1'b1, MODE_DIM);
        write_cfg(3, 3, MODE_DELAY_DIM, 1'b0, 0);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_fx_en", fx_en, 0);
        check("mid_rst_fx_mode", fx_mode, 0);
        check("mid_rst_line_cnt", line_cnt, 0);
        check("mid_rst_ack", cfg_ack, 0);
        check("mid_rst_tick", frame_tick, 0);
        rst = 1'b0;
        cyc(2);
        frame("post_rst", 1'b0);
        check("post_rst_mode", fx_mode, MODE_PASS);
        line(1'b0, MODE_PASS);
        line(1'b0, MODE_PASS);
        hs = 1'b1;
        vs = 1'b1;
        cyc(1);
        hs = 1'b0;
        vs = 1'b0;
        cyc(2);
        check("hsvs_line_cnt", line_cnt, 0);
        check("hsvs_tick", frame_tick, 1);
        check("hsvs_fx_en", fx_en, 0);
        cyc(4);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
